// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types and constants for the N-digit BCD scoreboard
package scoreboard_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_COUNT = 2'd1,
        CLR_FIRE  = 2'd2
    } clr_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/scoreboard_clr_seq.sv
// rtl/scoreboard_clr_seq.sv - timed multi-press clear sequencer with inter-press window
module scoreboard_clr_seq
    import scoreboard_pkg::*;
#(
    parameter int CLR_PRESS_COUNT  = 5,
    parameter int CLR_WINDOW_TICKS = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       clr_btn,
    output logic       clr_fire,
    output logic [3:0] clr_progress
);

    localparam logic [3:0]  PRESS_TARGET = 4'(CLR_PRESS_COUNT);
    localparam logic [15:0] WINDOW_LIMIT = 16'(CLR_WINDOW_TICKS);

    clr_state_t  state, state_nxt;
    logic [3:0]  progress, progress_nxt;
    logic [15:0] window, window_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLR_IDLE;
            progress <= '0;
            window   <= '0;
        end else begin
            state    <= state_nxt;
            progress <= progress_nxt;
            window   <= window_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        progress_nxt = progress;
        window_nxt   = window;
        if (tick_en) begin
            unique case (state)
                CLR_IDLE: begin
                    if (clr_btn) begin
                        progress_nxt = 4'd1;
                        window_nxt   = '0;
                        state_nxt    = (PRESS_TARGET == 4'd1) ? CLR_FIRE : CLR_COUNT;
                    end
                end
                CLR_COUNT: begin
                    if (clr_btn) begin
                        progress_nxt = progress + 4'd1;
                        window_nxt   = '0;
                        if (progress + 4'd1 == PRESS_TARGET)
                            state_nxt = CLR_FIRE;
                    end else if (window + 16'd1 == WINDOW_LIMIT) begin
                        // Gap between presses too long: abandon the sequence
                        progress_nxt = '0;
                        window_nxt   = '0;
                        state_nxt    = CLR_IDLE;
                    end else begin
                        window_nxt = window + 16'd1;
                    end
                end
                CLR_FIRE: begin
                    progress_nxt = '0;
                    window_nxt   = '0;
                    state_nxt    = CLR_IDLE;
                end
                default: begin
                    progress_nxt = '0;
                    window_nxt   = '0;
                    state_nxt    = CLR_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        clr_fire     = (state == CLR_FIRE);
        clr_progress = progress;
    end

endmodule

// File: rtl/sseg_encoder.sv
// rtl/sseg_encoder.sv - single BCD digit to active-high 7-segment pattern
module sseg_encoder
    import scoreboard_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [6:0]       seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scoreboard_ndigit.sv
// rtl/bcd_scoreboard_ndigit.sv - N-digit BCD scoreboard; optional SCOREBOARD_LEADING_ZERO_BLANK_EN blanks leading zeros
module bcd_scoreboard_ndigit
    import scoreboard_pkg::*;
#(
    parameter int NUM_DIGITS       = 2,
    parameter int WRAP_MODE        = 0,
    parameter int CLR_PRESS_COUNT  = 5,
    parameter int CLR_WINDOW_TICKS = 200,
    parameter int SEG_POLARITY     = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick_en,
    input  logic                        incr,
    input  logic                        decr,
    input  logic [1:0]                  incr_amt,
    input  logic                        clr_btn,
    output logic [BCD_W*NUM_DIGITS-1:0] bcd_out,
    output logic [7*NUM_DIGITS-1:0]     sseg_out,
    output logic [3:0]                  clr_progress,
    output logic                        ovf,
    output logic                        unf
);

    localparam int SW = BCD_W * NUM_DIGITS;
    localparam logic [SW-1:0] MAX_SCORE = {NUM_DIGITS{4'd9}};

    logic [SW-1:0] score, score_nxt, inc_sum, dec_diff;
    logic          inc_carry, dec_borrow, ovf_nxt, unf_nxt, clr_fire;
    logic [4:0]    add_s;
    logic [3:0]    add_c;
    logic [3:0]    dig;

    scoreboard_clr_seq #(
        .CLR_PRESS_COUNT  (CLR_PRESS_COUNT),
        .CLR_WINDOW_TICKS (CLR_WINDOW_TICKS)
    ) u_clr_seq (
        .clk          (clk),
        .reset        (reset),
        .tick_en      (tick_en),
        .clr_btn      (clr_btn),
        .clr_fire     (clr_fire),
        .clr_progress (clr_progress)
    );

    // Ripple-carry BCD add of 1..3; the final carry is the overflow
    always_comb begin
        add_s   = '0;
        add_c   = (incr_amt == 2'd0) ? 4'd1 : {2'b00, incr_amt};
        inc_sum = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            add_s = {1'b0, score[i*BCD_W +: BCD_W]} + {1'b0, add_c};
            if (add_s >= 5'd10) begin
                inc_sum[i*BCD_W +: BCD_W] = 4'(add_s - 5'd10);
                add_c = 4'd1;
            end else begin
                inc_sum[i*BCD_W +: BCD_W] = add_s[3:0];
                add_c = 4'd0;
            end
        end
        inc_carry = (add_c != 4'd0);
    end

    // Borrow out of the top digit means the score was zero; result is then all nines
    always_comb begin
        dig        = '0;
        dec_borrow = 1'b1;
        dec_diff   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = score[i*BCD_W +: BCD_W];
            if (!dec_borrow) begin
                dec_diff[i*BCD_W +: BCD_W] = dig;
            end else if (dig == 4'd0) begin
                dec_diff[i*BCD_W +: BCD_W] = 4'd9;
            end else begin
                dec_diff[i*BCD_W +: BCD_W] = dig - 4'd1;
                dec_borrow = 1'b0;
            end
        end
    end

    always_comb begin
        score_nxt = score;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (tick_en) begin
            if (clr_fire) begin
                score_nxt = '0;
            end else if (incr && !decr) begin
                ovf_nxt   = inc_carry;
                score_nxt = (inc_carry && WRAP_MODE == 0) ? MAX_SCORE : inc_sum;
            end else if (decr && !incr) begin
                unf_nxt   = dec_borrow;
                score_nxt = (dec_borrow && WRAP_MODE == 0) ? '0 : dec_diff;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            score <= score_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

    assign bcd_out = score;

    logic [NUM_DIGITS-1:0] blank;

`ifdef SCOREBOARD_LEADING_ZERO_BLANK_EN
    logic lead_zero;
    always_comb begin
        blank     = '0;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead_zero = lead_zero && (score[i*BCD_W +: BCD_W] == 4'd0);
            blank[i]  = lead_zero;
        end
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            logic [6:0] raw_seg, on_seg;
            sseg_encoder u_enc (
                .digit (score[g*BCD_W +: BCD_W]),
                .seg   (raw_seg)
            );
            assign on_seg = blank[g] ? SEG_BLANK : raw_seg;
            assign sseg_out[g*7 +: 7] = (SEG_POLARITY != 0) ? on_seg : ~on_seg;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_scoreboard_ndigit.sv
// tb/tb_bcd_scoreboard_ndigit.sv - directed bench for saturating and wrapping scoreboard builds
module tb_bcd_scoreboard_ndigit;

    logic        clk = 1'b0;
    logic        reset, tick_en, incr, decr, clr_btn;
    logic [1:0]  incr_amt;
    logic [7:0]  bcd_s, bcd_w;
    logic [13:0] sseg_s, sseg_w;
    logic [3:0]  prog_s, prog_w;
    logic        ovf_s, unf_s, ovf_w, unf_w;
    int          errors = 0;
    int          checks = 0;
    logic        any_flag;

    localparam logic [13:0] SSEG_00 = {7'h3F, 7'h3F};
    localparam logic [13:0] SSEG_12 = {7'h06, 7'h5B};

    always #5 clk = ~clk;

    bcd_scoreboard_ndigit #(.WRAP_MODE(0)) dut_sat (
        .clk(clk), .reset(reset), .tick_en(tick_en), .incr(incr), .decr(decr),
        .incr_amt(incr_amt), .clr_btn(clr_btn), .bcd_out(bcd_s), .sseg_out(sseg_s),
        .clr_progress(prog_s), .ovf(ovf_s), .unf(unf_s)
    );

    bcd_scoreboard_ndigit #(.WRAP_MODE(1)) dut_wrap (
        .clk(clk), .reset(reset), .tick_en(tick_en), .incr(incr), .decr(decr),
        .incr_amt(incr_amt), .clr_btn(clr_btn), .bcd_out(bcd_w), .sseg_out(sseg_w),
        .clr_progress(prog_w), .ovf(ovf_w), .unf(unf_w)
    );

    typedef struct {
        string      name;
        logic       inc;
        logic       dec;
        logic [1:0] amt;
        logic [7:0] exp_s;
        logic [7:0] exp_w;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_tick(input logic i, input logic d, input logic [1:0] a, input logic c);
        repeat (2) @(negedge clk);
        incr = i; decr = d; incr_amt = a; clr_btn = c; tick_en = 1'b1;
        @(posedge clk);
        #1;
        tick_en = 1'b0; incr = 1'b0; decr = 1'b0; incr_amt = 2'd0; clr_btn = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{"amt0_as_1",  1'b1, 1'b0, 2'd0, 8'h13, 8'h13, 1'b0, 1'b0};
        vecs[1] = '{"amt3",       1'b1, 1'b0, 2'd3, 8'h16, 8'h16, 1'b0, 1'b0};
        vecs[2] = '{"amt2",       1'b1, 1'b0, 2'd2, 8'h18, 8'h18, 1'b0, 1'b0};
        vecs[3] = '{"decr",       1'b0, 1'b1, 2'd0, 8'h17, 8'h17, 1'b0, 1'b0};
        vecs[4] = '{"incr_decr",  1'b1, 1'b1, 2'd3, 8'h17, 8'h17, 1'b0, 1'b0};
        vecs[5] = '{"carry",      1'b1, 1'b0, 2'd3, 8'h20, 8'h20, 1'b0, 1'b0};
        vecs[6] = '{"borrow",     1'b0, 1'b1, 2'd0, 8'h19, 8'h19, 1'b0, 1'b0};

        reset = 1'b1; tick_en = 1'b0; incr = 1'b0; decr = 1'b0; incr_amt = 2'd0; clr_btn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_bcd",  {bcd_s, bcd_w}, 16'h0000);
        check("reset_sseg", {sseg_s, sseg_w}, {SSEG_00, SSEG_00});
        check("reset_prog", {prog_s, prog_w}, 8'h00);
        check("reset_flags", {ovf_s, unf_s, ovf_w, unf_w}, 4'b0000);

        any_flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_tick(1'b1, 1'b0, 2'd1, 1'b0);
            any_flag = any_flag | ovf_s | ovf_w | unf_s | unf_w;
        end
        check("count12_bcd",  {bcd_s, bcd_w}, 16'h1212);
        check("count12_sseg", sseg_s, SSEG_12);
        check("count12_noflag", any_flag, 1'b0);

        for (int i = 0; i < 7; i++) begin
            do_tick(vecs[i].inc, vecs[i].dec, vecs[i].amt, 1'b0);
            check({vecs[i].name, "_sat"},  bcd_s, vecs[i].exp_s);
            check({vecs[i].name, "_wrap"}, bcd_w, vecs[i].exp_w);
            check({vecs[i].name, "_flags"}, {ovf_s, unf_s, ovf_w, unf_w},
                  {vecs[i].exp_ovf, vecs[i].exp_unf, vecs[i].exp_ovf, vecs[i].exp_unf});
        end

        // 19 + 26*3 + 1 = 98
        any_flag = 1'b0;
        for (int i = 0; i < 26; i++) begin
            do_tick(1'b1, 1'b0, 2'd3, 1'b0);
            any_flag = any_flag | ovf_s | ovf_w;
        end
        do_tick(1'b1, 1'b0, 2'd1, 1'b0);
        check("to98_bcd", {bcd_s, bcd_w}, 16'h9898);
        check("to98_noovf", any_flag, 1'b0);

        do_tick(1'b1, 1'b0, 2'd3, 1'b0);
        check("ovf_sat_bcd",  bcd_s, 8'h99);
        check("ovf_wrap_bcd", bcd_w, 8'h01);
        check("ovf_pulse",    {ovf_s, ovf_w, unf_s, unf_w}, 4'b1100);
        @(posedge clk); #1;
        check("ovf_one_clk",  {ovf_s, ovf_w}, 2'b00);

        do_reset();
        do_tick(1'b0, 1'b1, 2'd0, 1'b0);
        check("unf_sat_bcd",  bcd_s, 8'h00);
        check("unf_wrap_bcd", bcd_w, 8'h99);
        check("unf_pulse",    {unf_s, unf_w, ovf_s, ovf_w}, 4'b1100);
        @(posedge clk); #1;
        check("unf_one_clk",  {unf_s, unf_w}, 2'b00);

        // Clear sequence from 47: 15*3 + 2
        do_reset();
        for (int i = 0; i < 15; i++) do_tick(1'b1, 1'b0, 2'd3, 1'b0);
        do_tick(1'b1, 1'b0, 2'd2, 1'b0);
        check("pre_clr_bcd", {bcd_s, bcd_w}, 16'h4747);
        for (int k = 1; k <= 5; k++) begin
            do_tick(1'b0, 1'b0, 2'd0, 1'b1);
            if (k < 5) begin
                check($sformatf("clr_prog_%0d", k), {prog_s, prog_w}, {4'(k), 4'(k)});
                for (int j = 0; j < 9; j++) do_tick(1'b0, 1'b0, 2'd0, 1'b0);
                check($sformatf("clr_hold_%0d", k), {bcd_s, bcd_w}, 16'h4747);
            end
        end
        check("clr_5th_press_bcd", {bcd_s, bcd_w}, 16'h4747);
        do_tick(1'b1, 1'b0, 2'd1, 1'b0);
        check("clr_fire_bcd",  {bcd_s, bcd_w}, 16'h0000);
        check("clr_fire_prog", {prog_s, prog_w}, 8'h00);

        // Window expiry
        do_tick(1'b1, 1'b0, 2'd2, 1'b0);
        do_tick(1'b1, 1'b0, 2'd3, 1'b0);
        for (int k = 0; k < 3; k++) do_tick(1'b0, 1'b0, 2'd0, 1'b1);
        check("win_prog3", {prog_s, prog_w}, 8'h33);
        for (int j = 0; j < 199; j++) do_tick(1'b0, 1'b0, 2'd0, 1'b0);
        check("win_199_prog", {prog_s, prog_w}, 8'h33);
        do_tick(1'b0, 1'b0, 2'd0, 1'b0);
        check("win_200_prog", {prog_s, prog_w}, 8'h00);
        check("win_bcd",      {bcd_s, bcd_w}, 16'h0505);
        for (int k = 0; k < 2; k++) do_tick(1'b0, 1'b0, 2'd0, 1'b1);
        check("win_restart_prog", {prog_s, prog_w}, 8'h22);
        do_tick(1'b0, 1'b0, 2'd0, 1'b0);
        check("win_restart_bcd", {bcd_s, bcd_w}, 16'h0505);
        do_tick(1'b0, 1'b0, 2'd0, 1'b1);
        check("pre_areset_prog", {prog_s, prog_w}, 8'h33);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_bcd",   {bcd_s, bcd_w}, 16'h0000);
        check("areset_prog",  {prog_s, prog_w}, 8'h00);
        check("areset_sseg",  {sseg_s, sseg_w}, {SSEG_00, SSEG_00});
        check("areset_flags", {ovf_s, unf_s, ovf_w, unf_w}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scoreboard_ndigit.md
Name: bcd_scoreboard_ndigit

Overview:
- Parametrised N-digit BCD scoreboard core; successor to the fixed two-digit scoreboard.
- Adds multi-point increments (1-3), selectable saturate/wrap arithmetic, over/underflow flags, and a timed multi-press clear sequencer.
- Runs on the system clock, qualified by an external tick enable from clk_divider.
- Sits behind input_logic (conditioned single-cycle button pulses) and ahead of the display mux.

Parameters:
- NUM_DIGITS, 2: BCD digits; range 1..8; max score 10^NUM_DIGITS-1.
- WRAP_MODE, 0: 0 = saturate at 0 / max; 1 = wrap modulo 10^NUM_DIGITS.
- CLR_PRESS_COUNT, 5: clear presses needed to clear the score; range 1..15.
- CLR_WINDOW_TICKS, 200: ticks allowed between consecutive clear presses before the sequence aborts; range 1..65535.
- SEG_POLARITY, 1: 1 = segments active-high; 0 = segments inverted.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- tick_en  in  1  one-clk enable pulse from clk_divider; all state advances only when tick_en=1.
- incr  in  1  conditioned increment request.
- decr  in  1  conditioned decrement request.
- incr_amt  in  2  points per increment (1-3); 0 is treated as 1.
- clr_btn  in  1  conditioned clear-button press.
- bcd_out  out  4*NUM_DIGITS  score; digit 0 is bits [3:0].
- sseg_out  out  7*NUM_DIGITS  per-digit 7-segment patterns; digit 0 is bits [6:0].
- clr_progress  out  4  presses counted in the current clear sequence.
- ovf  out  1  one-clk pulse on an overflow event.
- unf  out  1  one-clk pulse on an underflow event.

Behaviour:
- Reset: bcd_out=0, clr_progress=0, ovf=unf=0, FSM=IDLE, window counter=0. sseg_out shows all zeros (subject to the optional feature).
- Events are sampled only on clk edges where tick_en=1. bcd_out updates on that same edge (one-clk latency). sseg_out is combinational from the bcd register.
- Priority on a tick: clear fire > (incr & decr: no change, no flags) > incr > decr.
- Increment:
  - Score += max(incr_amt,1), ripple-carry BCD across all digits.
  - If the result exceeds max: saturate mode holds max; wrap mode takes result-10^N. Either way ovf pulses.
  - Example, 2 digits, 98+3: saturate gives 99; wrap gives 01.
- Decrement:
  - Score -= 1 with BCD borrow.
  - At 0: saturate mode holds 0; wrap mode goes to max. Either way unf pulses.
- Clear sequencer FSM (states IDLE, COUNT, FIRE):
  - IDLE: a ticked clr_btn sets progress=1, window=0 and moves to COUNT. If CLR_PRESS_COUNT==1 it moves to FIRE instead.
  - COUNT:
    - Ticked clr_btn: progress+1 and window reset. When progress reaches CLR_PRESS_COUNT, move to FIRE.
    - Ticked without a press: window+1. When window reaches CLR_WINDOW_TICKS, progress=0 and return to IDLE.
  - FIRE: score cleared to 0 on the next ticked edge; progress=0, return to IDLE. Any incr/decr in that tick is discarded.
  - The clear fires on exactly the CLR_PRESS_COUNT-th press, never one press later.
- ovf/unf are high for a single clk, not a whole tick period.
- Reset asserted mid-sequence aborts immediately to reset values.
- Non-BCD digit values are unreachable. The encoder maps codes 10-15 to all segments off.

Optional Feature:
- Macro: SCOREBOARD_LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits above digit 0 drive all segments off (polarity-adjusted). Digit 0 is always shown. bcd_out is unaffected.
- Undefined: all digits always displayed, including leading zeros.

Decomposition:
- Shared package scoreboard_pkg holds:
  - clear-FSM state encoding (IDLE/COUNT/FIRE);
  - 7-bit segment constants for digits 0-9 and BLANK;
  - BCD digit width constant (4).
- Sub-module scoreboard_clr_seq: the clear FSM plus window counter. Outputs clr_fire and clr_progress.
- Per-digit segment encoding reuses the existing sseg_encoder in a generate loop.

Test Plan:
- Reset then 12 ticked incr with incr_amt=1 -> bcd_out=0x12; sseg digit1="1", digit0="2"; no ovf.
- WRAP_MODE=0: score 98, incr_amt=3 -> 0x99, ovf one clk. Then decr from 00 -> stays 00, unf pulses.
- WRAP_MODE=1: score 98, incr_amt=3 -> 0x01, ovf pulses. Decr at 00 -> 0x99, unf pulses.
- Score 47, 5 clr presses 10 ticks apart -> clr_progress 1..4, then 0x00 one tick after the 5th press. A 4th press alone does not clear.
- 3 clr presses, then 200 idle ticks -> clr_progress=0, score unchanged. 2 further presses do not clear.
- incr and decr on the same tick -> score unchanged, no flags. Reset asserted while clr_progress=3 -> all outputs return to reset values asynchronously.
